wd_supervisor: RTL and testbench



---
 rtl/wd_supervisor.sv | 153 +++++++++++++++
 tb/tb_wd_supervisor.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wd_supervisor.sv
// Watchdog supervisor: two-byte service key, overflow warning with grace period, held reset request.
// Define WD_LOCK_EN to ignore EN once the block has left IDLE (only SYSRST disarms it).
module wd_supervisor #(
   parameter logic [7:0] KEY_A       = 8'h55,
   parameter logic [7:0] KEY_B       = 8'hAA,
   parameter logic [7:0] GRACE_LEN   = 8'd16,
   parameter logic [1:0] MAX_STRIKES = 2'd3
) (
   input  logic       WDCLK,
   input  logic       SYSRST,
   input  logic       EN,
   input  logic       KEY_WR,
   input  logic [7:0] KEY_DATA,
   input  logic       IRQ_ACK,
   input  logic       FW_OVR,
   output logic       FW_SRVC,
   output logic       FW_CLR,
   output logic       WD_IRQ,
   output logic       WD_RSTREQ,
   output logic [2:0] WD_STATE,
   output logic [1:0] STRIKES
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      KEY1  = 3'd2,
      WARN  = 3'd3,
      BITE  = 3'd4
   } state_t;

   state_t     state, state_n;
   logic [1:0] strikes, strikes_n, strike_inc;
   logic [7:0] grace, grace_n;
   logic       srvc, srvc_n, clr, clr_n, irq, irq_n, rstreq, rstreq_n;
   logic       disable_req, bite;

   always_comb begin
      strike_inc = (strikes == 2'd3) ? 2'd3 : strikes + 2'd1;
`ifdef WD_LOCK_EN
      disable_req = 1'b0;
`else
      disable_req = !EN && (state != IDLE) && (state != BITE);
`endif
   end

   always_comb begin
      state_n   = state;
      strikes_n = strikes;
      grace_n   = grace;
      srvc_n    = 1'b0;
      clr_n     = 1'b0;
      irq_n     = irq;
      rstreq_n  = rstreq;
      bite      = 1'b0;
      if (disable_req) begin
         state_n = IDLE;
         irq_n   = 1'b0;
         grace_n = '0;
         clr_n   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               clr_n    = 1'b1;
               irq_n    = 1'b0;
               rstreq_n = 1'b0;
               if (EN) begin
                  state_n = ARMED;
                  clr_n   = 1'b0;
               end
            end
            ARMED, KEY1: begin
               // Overflow outranks any key write this cycle and discards a pending KEY_A
               if (FW_OVR) begin
                  strikes_n = strike_inc;
                  if (strike_inc >= MAX_STRIKES) begin
                     bite = 1'b1;
                  end else begin
                     state_n = WARN;
                     irq_n   = 1'b1;
                     clr_n   = 1'b1;
                     grace_n = '0;
                  end
               end else if (KEY_WR) begin
                  if (state == ARMED) begin
                     if (KEY_DATA == KEY_A) state_n = KEY1;
                  end else if (KEY_DATA == KEY_B) begin
                     srvc_n  = 1'b1;
                     state_n = ARMED;
                  end else begin
                     strikes_n = strike_inc;
                     if (strike_inc >= MAX_STRIKES) bite = 1'b1;
                     else state_n = ARMED;
                  end
               end
            end
            WARN: begin
               grace_n = grace + 8'd1;
               if (IRQ_ACK) begin
                  irq_n   = 1'b0;
                  clr_n   = 1'b1;
                  state_n = ARMED;
               end else if (grace == GRACE_LEN - 8'd1) begin
                  bite = 1'b1;
               end
            end
            BITE: begin
               rstreq_n = 1'b1;
               irq_n    = 1'b1;
               clr_n    = 1'b1;
            end
            default: begin
               state_n = IDLE;
               clr_n   = 1'b1;
            end
         endcase
         if (bite) begin
            state_n  = BITE;
            rstreq_n = 1'b1;
            irq_n    = 1'b1;
            clr_n    = 1'b1;
         end
      end
   end

   always_ff @(posedge WDCLK) begin
      if (SYSRST) begin
         state   <= IDLE;
         strikes <= '0;
         grace   <= '0;
         srvc    <= 1'b0;
         clr     <= 1'b1;
         irq     <= 1'b0;
         rstreq  <= 1'b0;
      end else begin
         state   <= state_n;
         strikes <= strikes_n;
         grace   <= grace_n;
         srvc    <= srvc_n;
         clr     <= clr_n;
         irq     <= irq_n;
         rstreq  <= rstreq_n;
      end
   end

   assign FW_SRVC   = srvc;
   assign FW_CLR    = clr;
   assign WD_IRQ    = irq;
   assign WD_RSTREQ = rstreq;
   assign WD_STATE  = state;
   assign STRIKES   = strikes;

endmodule

// File: tb/tb_wd_supervisor.sv
// Scoreboard bench for wd_supervisor: the driver queues the required output snapshot per cycle,
// a negedge monitor pops and compares them. Expected values honour WD_LOCK_EN when defined.
module tb_wd_supervisor;

   localparam logic [2:0] SI = 3'd0, SA = 3'd1, SK = 3'd2, SW = 3'd3, SB = 3'd4;

   logic       clk = 1'b0;
   logic       sysrst = 1'b1, en = 1'b0, key_wr = 1'b0, irq_ack = 1'b0, fw_ovr = 1'b0;
   logic [7:0] key_data = 8'h00;
   logic       fw_srvc, fw_clr, wd_irq, wd_rstreq;
   logic [2:0] wd_state;
   logic [1:0] strikes;

   typedef struct {
      int         tag;
      logic [8:0] vec;
      string      name;
   } exp_t;

   exp_t q[$];
   int   nneg = 0;
   int   checks = 0;
   int   errors = 0;

   wd_supervisor #(.KEY_A(8'h55), .KEY_B(8'hAA), .GRACE_LEN(8'd16), .MAX_STRIKES(2'd3)) dut (
      .WDCLK(clk), .SYSRST(sysrst), .EN(en), .KEY_WR(key_wr), .KEY_DATA(key_data),
      .IRQ_ACK(irq_ack), .FW_OVR(fw_ovr), .FW_SRVC(fw_srvc), .FW_CLR(fw_clr),
      .WD_IRQ(wd_irq), .WD_RSTREQ(wd_rstreq), .WD_STATE(wd_state), .STRIKES(strikes)
   );

   always #5 clk = ~clk;

   // Monitor: each snapshot is due at the negedge following the edge that sampled its stimulus
   always @(negedge clk) begin
      logic [8:0] act;
      exp_t       e;
      nneg = nneg + 1;
      act  = {wd_state, strikes, fw_srvc, fw_clr, wd_irq, wd_rstreq};
      while (q.size() > 0 && q[0].tag <= nneg) begin
         e = q.pop_front();
         checks = checks + 1;
         if (e.tag != nneg || act !== e.vec) begin
            errors = errors + 1;
            $display("FAIL %s @%0d: got st=%0d stk=%0d srvc=%b clr=%b irq=%b rreq=%b, want st=%0d stk=%0d srvc=%b clr=%b irq=%b rreq=%b",
                     e.name, nneg, act[8:6], act[5:4], act[3], act[2], act[1], act[0],
                     e.vec[8:6], e.vec[5:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
         end
      end
   end

   task automatic step(input logic rst, input logic en_i, input logic kw, input logic [7:0] kd,
                       input logic ack, input logic ovr, input logic [2:0] st, input logic [1:0] stk,
                       input logic srvc, input logic clr, input logic irq, input logic rreq,
                       input string name);
      exp_t e;
      @(posedge clk);
      #1;
      sysrst = rst; en = en_i; key_wr = kw; key_data = kd; irq_ack = ack; fw_ovr = ovr;
      e.tag  = nneg + 2;
      e.vec  = {st, stk, srvc, clr, irq, rreq};
      e.name = name;
      q.push_back(e);
   endtask

   initial begin
      #1_000_000;
      errors = errors + 1;
      $display("FAIL timeout: simulation did not complete, want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      // Service
      step(1, 0, 0, 8'h00, 0, 0, SI, 0, 0, 1, 0, 0, "reset");
      step(0, 0, 0, 8'h00, 0, 0, SI, 0, 0, 1, 0, 0, "idle_en0");
      step(0, 1, 0, 8'h00, 0, 0, SA, 0, 0, 0, 0, 0, "arm");
      step(0, 1, 1, 8'h55, 0, 0, SK, 0, 0, 0, 0, 0, "key_a");
      step(0, 1, 0, 8'h00, 0, 0, SK, 0, 0, 0, 0, 0, "key1_hold");
      step(0, 1, 1, 8'hAA, 0, 0, SA, 0, 1, 0, 0, 0, "service_pulse");
      step(0, 1, 0, 8'h00, 0, 0, SA, 0, 0, 0, 0, 0, "service_end");
      // Bad keys, third one bites
      step(0, 1, 1, 8'h12, 0, 0, SA, 0, 0, 0, 0, 0, "armed_ignore");
      for (int i = 0; i < 2; i++) begin
         step(0, 1, 1, 8'h55, 0, 0, SK, 2'(i), 0, 0, 0, 0, "bad_key_a");
         step(0, 1, 1, 8'h12, 0, 0, SA, 2'(i + 1), 0, 0, 0, 0, "bad_key");
      end
      step(0, 1, 1, 8'h55, 0, 0, SK, 2, 0, 0, 0, 0, "bad_key_a3");
      step(0, 1, 1, 8'h12, 0, 0, SB, 3, 0, 1, 1, 1, "third_bad_bite");
      step(0, 1, 1, 8'h55, 0, 0, SB, 3, 0, 1, 1, 1, "bite_hold");
      step(0, 0, 0, 8'h00, 0, 0, SB, 3, 0, 1, 1, 1, "bite_ignores_en");
      step(1, 1, 0, 8'h00, 0, 0, SI, 0, 0, 1, 0, 0, "reset_from_bite");
      // Acked overflow
      step(0, 1, 0, 8'h00, 0, 0, SA, 0, 0, 0, 0, 0, "arm2");
      step(0, 1, 0, 8'h00, 0, 1, SW, 1, 0, 1, 1, 0, "ovr_warn");
      step(0, 1, 0, 8'h00, 0, 0, SW, 1, 0, 0, 1, 0, "ovr_clr_end");
      for (int i = 0; i < 8; i++)
         step(0, 1, (i == 3), 8'h55, 0, (i == 5), SW, 1, 0, 0, 1, 0, "warn_ignores");
      step(0, 1, 0, 8'h00, 1, 0, SA, 1, 0, 1, 0, 0, "ack");
      step(0, 1, 0, 8'h00, 0, 0, SA, 1, 0, 0, 0, 0, "ack_clr_end");
      // Grace expiry: 16 cycles from WD_IRQ rising to WD_RSTREQ
      step(0, 1, 0, 8'h00, 0, 1, SW, 2, 0, 1, 1, 0, "ovr2");
      for (int i = 0; i < 15; i++)
         step(0, 1, 0, 8'h00, 0, 0, SW, 2, 0, 0, 1, 0, "grace_wait");
      step(0, 1, 0, 8'h00, 0, 0, SB, 2, 0, 1, 1, 1, "grace_bite");
      step(0, 1, 0, 8'h00, 1, 0, SB, 2, 0, 1, 1, 1, "bite_ignores_ack");
      step(0, 0, 0, 8'h00, 0, 0, SB, 2, 0, 1, 1, 1, "bite_hold_en0");
      step(1, 0, 0, 8'h00, 0, 0, SI, 0, 0, 1, 0, 0, "reset_mid_bite");
      // Simultaneous events
      step(0, 1, 0, 8'h00, 0, 0, SA, 0, 0, 0, 0, 0, "arm3");
      step(0, 1, 1, 8'h55, 0, 0, SK, 0, 0, 0, 0, 0, "key_a3");
      step(0, 1, 1, 8'hAA, 0, 1, SW, 1, 0, 1, 1, 0, "ovr_beats_key");
      for (int i = 0; i < 15; i++)
         step(0, 1, 0, 8'h00, 0, 0, SW, 1, 0, 0, 1, 0, "grace_wait2");
      step(0, 1, 0, 8'h00, 1, 0, SA, 1, 0, 1, 0, 0, "ack_on_expiry");
      step(0, 1, 0, 8'h00, 0, 0, SA, 1, 0, 0, 0, 0, "ack_expiry_end");
      // Strike count reaching MAX_STRIKES via overflow bites instead of warning
      step(0, 1, 0, 8'h00, 0, 1, SW, 2, 0, 1, 1, 0, "ovr_strike2");
      step(0, 1, 0, 8'h00, 1, 0, SA, 2, 0, 1, 0, 0, "ack_strike2");
      step(0, 1, 0, 8'h00, 0, 1, SB, 3, 0, 1, 1, 1, "ovr_max_bite");
      step(1, 1, 0, 8'h00, 0, 0, SI, 0, 0, 1, 0, 0, "reset4");
      // Disable path
      step(0, 1, 0, 8'h00, 0, 0, SA, 0, 0, 0, 0, 0, "arm5");
      step(0, 1, 0, 8'h00, 0, 1, SW, 1, 0, 1, 1, 0, "ovr5");
`ifdef WD_LOCK_EN
      step(0, 0, 0, 8'h00, 0, 0, SW, 1, 0, 0, 1, 0, "disable_locked");
      step(0, 0, 0, 8'h00, 0, 0, SW, 1, 0, 0, 1, 0, "disable_locked_hold");
      step(0, 1, 0, 8'h00, 0, 0, SW, 1, 0, 0, 1, 0, "reenable_locked");
`else
      step(0, 0, 0, 8'h00, 0, 0, SI, 1, 0, 1, 0, 0, "disable_warn");
      step(0, 0, 0, 8'h00, 0, 0, SI, 1, 0, 1, 0, 0, "disable_hold");
      step(0, 1, 0, 8'h00, 0, 0, SA, 1, 0, 0, 0, 0, "reenable_keeps_strikes");
`endif
      step(1, 0, 0, 8'h00, 0, 0, SI, 0, 0, 1, 0, 0, "final_reset");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d snapshots never compared, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
